// File: rtl/des_key_sched.sv
// des_key_sched: iterative DES/3DES key schedule producing K1..K16 (or K16..K1) one per handshake.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   key_in       64-bit DES key including parity bits (FIPS bits 8,16,..,64)
//   key_load     one-cycle strobe: latch key_in/decrypt and start a schedule (aborts a running one)
//   decrypt      0 = K1..K16 order, 1 = K16..K1 order, sampled with key_load
//   busy         high while a schedule is being emitted
//   sk_valid     subkey is valid
//   sk_ready     consumer accepts the subkey
//   subkey       registered 48-bit PC-2 output, zero when sk_valid is low
//   sk_index     FIPS subkey index minus 1 (0 = K1 .. 15 = K16)
//   done         one-cycle pulse after the last subkey is accepted
//   key_par_err  byte odd-parity violation of the loaded key
//
// Build option: define DES_KS_PARITY_EN to enable the key parity checker;
// otherwise key_par_err is tied low and no parity logic exists.
module des_key_sched #(
    parameter int NROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key_in,
    input  logic        key_load,
    input  logic        decrypt,
    output logic        busy,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [47:0] subkey,
    output logic [3:0]  sk_index,
    output logic        done,
    output logic        key_par_err
);

    typedef enum logic {IDLE, GEN} state_t;

    localparam logic [3:0] LAST = 4'(NROUNDS - 1);

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // FIPS bit n of a W-bit vector lives at vector bit W-n
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  dst;
        logic [5:0]  src;
        r = '0;
        for (int n = 0; n < 56; n++) begin
            dst    = 6'(55 - n);
            src    = 6'(64 - PC1_T[n]);
            r[dst] = k[src];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        logic [5:0]  dst;
        logic [5:0]  src;
        r = '0;
        for (int n = 0; n < 48; n++) begin
            dst    = 6'(47 - n);
            src    = 6'(56 - PC2_T[n]);
            r[dst] = cd[src];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // shift schedule s[i], i = 1..16: single shift at rounds 1, 2, 9 and 16
    function automatic logic dbl(input logic [4:0] i);
        return !(i == 5'd1 || i == 5'd2 || i == 5'd9 || i == 5'd16);
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  idx_q, idx_d;
    logic        dec_q, dec_d;
    logic        done_q, done_d;
    logic [47:0] subkey_q, subkey_d;
    logic [55:0] pc1_v;
    logic [27:0] c_ld, d_ld;
    logic [4:0]  sh_i;
    logic        two, hs, last;

    always_comb begin
        pc1_v    = pc1(key_in);
        c_ld     = pc1_v[55:28];
        d_ld     = pc1_v[27:0];
        hs       = (state_q == GEN) & sk_ready;
        last     = dec_q ? (idx_q == 4'd0) : (idx_q == LAST);
        // encrypt moves to round i+1 using s[i+1]; decrypt undoes round i using s[i]
        sh_i     = {1'b0, idx_q} + (dec_q ? 5'd1 : 5'd2);
        two      = dbl(sh_i);
        state_d  = state_q;
        c_d      = c_q;
        d_d      = d_q;
        idx_d    = idx_q;
        dec_d    = dec_q;
        done_d   = 1'b0;
        if (key_load) begin
            // decrypt starts from C0/D0, which equals C16/D16 since total rotation is 28
            state_d = GEN;
            dec_d   = decrypt;
            c_d     = decrypt ? c_ld : rotl(c_ld, 1'b0);
            d_d     = decrypt ? d_ld : rotl(d_ld, 1'b0);
            idx_d   = decrypt ? LAST : 4'd0;
        end else if (hs && last) begin
            state_d = IDLE;
            c_d     = '0;
            d_d     = '0;
            idx_d   = '0;
            done_d  = 1'b1;
        end else if (hs) begin
            c_d   = dec_q ? rotr(c_q, two) : rotl(c_q, two);
            d_d   = dec_q ? rotr(d_q, two) : rotl(d_q, two);
            idx_d = dec_q ? idx_q - 4'd1 : idx_q + 4'd1;
        end
        subkey_d = (state_d == GEN) ? pc2({c_d, d_d}) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            c_q      <= '0;
            d_q      <= '0;
            idx_q    <= '0;
            dec_q    <= 1'b0;
            done_q   <= 1'b0;
            subkey_q <= '0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            d_q      <= d_d;
            idx_q    <= idx_d;
            dec_q    <= dec_d;
            done_q   <= done_d;
            subkey_q <= subkey_d;
        end
    end

    assign sk_valid = (state_q == GEN);
    assign busy     = (state_q == GEN);
    assign subkey   = subkey_q;
    assign sk_index = idx_q;
    assign done     = done_q;

`ifdef DES_KS_PARITY_EN
    logic par_q, par_d, byte_err;

    always_comb begin
        byte_err = 1'b0;
        for (int b = 0; b < 8; b++) byte_err = byte_err | ~(^key_in[8*b +: 8]);
        par_d = key_load ? byte_err : par_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) par_q <= 1'b0;
        else par_q <= par_d;
    end

    assign key_par_err = par_q;
`else
    assign key_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_sched.sv
// tb_des_key_sched: directed self-checking bench for des_key_sched.
module tb_des_key_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] key_in = '0;
    logic        key_load = 1'b0;
    logic        decrypt = 1'b0;
    logic        busy;
    logic        sk_valid;
    logic        sk_ready = 1'b1;
    logic [47:0] subkey;
    logic [3:0]  sk_index;
    logic        done;
    logic        key_par_err;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B  = 64'h0E329232EA6D0D73;
    localparam logic [47:0] KB1    = 48'h36146478E1E1;

    localparam logic [47:0] KS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

`ifdef DES_KS_PARITY_EN
    localparam logic PAR_ZERO = 1'b1;
`else
    localparam logic PAR_ZERO = 1'b0;
`endif

    des_key_sched dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
        .decrypt(decrypt), .busy(busy), .sk_valid(sk_valid), .sk_ready(sk_ready),
        .subkey(subkey), .sk_index(sk_index), .done(done), .key_par_err(key_par_err)
    );

    always #5 clk = ~clk;

    task automatic load(input logic [63:0] k, input logic d);
        @(negedge clk);
        key_in   = k;
        decrypt  = d;
        key_load = 1'b1;
        @(posedge clk);
        #1 key_load = 1'b0;
        decrypt = 1'b0;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        key_in   = KEY_A;
        key_load = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        key_load = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, sk_valid, done, key_par_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, sk_valid, done, key_par_err});
        end
        checks++;
        if (subkey !== 48'h0 || sk_index !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: got subkey %h idx %0d expected 0 and 0", subkey, sk_index);
        end
        @(negedge clk);
        checks++;
        if (sk_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_load_ignored: got sk_valid %b expected 0", sk_valid);
        end
    endtask

    task automatic test_encrypt;
        int busy_cnt = 0;
        sk_ready = 1'b1;
        load(KEY_A, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            busy_cnt += int'(busy);
            checks++;
            if (subkey !== KS[i] || sk_index !== 4'(i) || sk_valid !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL enc_k%0d: got %h idx %0d v %b d %b expected %h idx %0d v 1 d 0",
                         i + 1, subkey, sk_index, sk_valid, done, KS[i], i);
            end
        end
        @(negedge clk);
        busy_cnt += int'(busy);
        checks++;
        if (done !== 1'b1 || sk_valid !== 1'b0 || subkey !== 48'h0) begin
            errors++;
            $display("FAIL enc_done: got done %b v %b subkey %h expected 1 0 0", done, sk_valid, subkey);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL enc_done_pulse: got done %b expected 0", done);
        end
        checks++;
        if (busy_cnt != 16) begin
            errors++;
            $display("FAIL enc_busy_cycles: got %0d expected 16", busy_cnt);
        end
    endtask

    task automatic test_decrypt;
        sk_ready = 1'b1;
        load(KEY_A, 1'b1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (subkey !== KS[15-i] || sk_index !== 4'(15 - i) || sk_valid !== 1'b1) begin
                errors++;
                $display("FAIL dec_k%0d: got %h idx %0d v %b expected %h idx %0d v 1",
                         16 - i, subkey, sk_index, sk_valid, KS[15-i], 15 - i);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || sk_valid !== 1'b0) begin
            errors++;
            $display("FAIL dec_done: got done %b v %b expected 1 0", done, sk_valid);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] pat = 32'hB5A36C9D;
        int exp_idx = 0;
        int hs = 0;
        int dn = 0;
        sk_ready = 1'b0;
        load(KEY_A, 1'b0);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done) dn++;
            if (sk_valid) begin
                checks++;
                if (exp_idx > 15) begin
                    errors++;
                    $display("FAIL bp_extra_valid: got idx %0d expected no valid subkey", sk_index);
                end else if (subkey !== KS[exp_idx] || sk_index !== 4'(exp_idx)) begin
                    errors++;
                    $display("FAIL bp_k%0d: got %h idx %0d expected %h idx %0d",
                             exp_idx + 1, subkey, sk_index, KS[exp_idx], exp_idx);
                end
            end
            sk_ready = pat[c % 32];
            if (sk_valid && sk_ready) begin
                hs++;
                exp_idx++;
            end
        end
        sk_ready = 1'b1;
        checks++;
        if (hs != 16 || dn != 1) begin
            errors++;
            $display("FAIL bp_counts: got %0d handshakes %0d done expected 16 and 1", hs, dn);
        end
    endtask

    task automatic test_abort;
        logic found = 1'b0;
        int dn = 0;
        sk_ready = 1'b1;
        load(KEY_A, 1'b0);
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (sk_valid && sk_index == 4'd7) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_wait: got no sk_index 7 expected it within 40 cycles");
        end
        key_in   = KEY_B;
        key_load = 1'b1;
        @(posedge clk);
        #1 key_load = 1'b0;
        @(negedge clk);
        checks++;
        if (subkey !== KB1 || sk_index !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart: got %h idx %0d done %b expected %h idx 0 done 0",
                     subkey, sk_index, done, KB1);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++;
        if (dn != 1) begin
            errors++;
            $display("FAIL abort_done_count: got %0d expected 1", dn);
        end
    endtask

    task automatic test_abort_last;
        logic found = 1'b0;
        int dn = 0;
        sk_ready = 1'b1;
        load(KEY_A, 1'b0);
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (sk_valid && sk_index == 4'd15) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_last_wait: got no sk_index 15 expected it within 40 cycles");
        end
        key_in   = KEY_A;
        decrypt  = 1'b1;
        key_load = 1'b1;
        @(posedge clk);
        #1 key_load = 1'b0;
        decrypt = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || subkey !== KS[15] || sk_index !== 4'd15) begin
            errors++;
            $display("FAIL abort_last: got done %b %h idx %0d expected 0 %h idx 15",
                     done, subkey, sk_index, KS[15]);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++;
        if (dn != 1) begin
            errors++;
            $display("FAIL abort_last_done_count: got %0d expected 1", dn);
        end
    endtask

    task automatic test_reset_mid;
        logic found = 1'b0;
        int dn = 0;
        sk_ready = 1'b1;
        load(KEY_A, 1'b0);
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (sk_valid && sk_index == 4'd5) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_mid_wait: got no sk_index 5 expected it within 40 cycles");
        end
        rst_n    = 1'b0;
        key_in   = KEY_B;
        key_load = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        key_load = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, sk_valid, done} !== 3'b0 || subkey !== 48'h0 || sk_index !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid: got b%b v%b d%b %h idx %0d expected all zero",
                     busy, sk_valid, done, subkey, sk_index);
        end
        load(KEY_B, 1'b0);
        @(negedge clk);
        checks++;
        if (subkey !== KB1 || sk_index !== 4'd0 || sk_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_reload: got %h idx %0d v %b expected %h idx 0 v 1",
                     subkey, sk_index, sk_valid, KB1);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++;
        if (dn != 1) begin
            errors++;
            $display("FAIL rst_mid_done_count: got %0d expected 1", dn);
        end
    endtask

    task automatic test_parity;
        sk_ready = 1'b0;
        load(64'h0, 1'b0);
        @(negedge clk);
        checks++;
        if (key_par_err !== PAR_ZERO || subkey !== 48'h0 || sk_valid !== 1'b1) begin
            errors++;
            $display("FAIL par_zero_key: got err %b subkey %h v %b expected %b 0 1",
                     key_par_err, subkey, sk_valid, PAR_ZERO);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (key_par_err !== PAR_ZERO) begin
            errors++;
            $display("FAIL par_hold: got %b expected %b", key_par_err, PAR_ZERO);
        end
        load(KEY_A, 1'b0);
        @(negedge clk);
        checks++;
        if (key_par_err !== 1'b0 || subkey !== KS[0]) begin
            errors++;
            $display("FAIL par_good_key: got err %b subkey %h expected 0 %h", key_par_err, subkey, KS[0]);
        end
        sk_ready = 1'b1;
    endtask

    initial begin
        test_reset;
        test_encrypt;
        test_decrypt;
        test_backpressure;
        test_abort;
        test_abort_last;
        test_reset_mid;
        test_parity;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
